// File: rtl/conv2_sched_if.sv
`default_nettype none
// ============================================================================
//  conv2_sched_if
//  Handshake and address bundle between the conv2 sequencer and the blocks
//  around it (layer control, weight ROM, pool1 feature RAM, MAC datapath).
//    slave  : the sequencer itself (takes start/stall, drives everything else)
//    master : the control / datapath side
//  Revision: 1.0  initial release
// ============================================================================
interface conv2_sched_if;
  logic       start;
  logic       stall;
  logic [7:0] k_addr0;
  logic [7:0] k_addr1;
  logic [9:0] fm_addr0;
  logic [9:0] fm_addr1;
  logic       rd_valid;
  logic       mac_en;
  logic       acc_clr;
  logic       out_we;
  logic [5:0] out_addr;
  logic       out_init;
  logic       busy;
  logic       done;

  modport slave (
    input  start, stall,
    output k_addr0, k_addr1, fm_addr0, fm_addr1, rd_valid, mac_en, acc_clr,
           out_we, out_addr, out_init, busy, done
  );

  modport master (
    output start, stall,
    input  k_addr0, k_addr1, fm_addr0, fm_addr1, rd_valid, mac_en, acc_clr,
           out_we, out_addr, out_init, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv2_sched.sv
`default_nettype none
// ============================================================================
//  conv2_sched
//  Address/control sequencer for the Convolution 2 layer. Walks
//  3 channel pairs x 64 output positions x 25 kernel taps, issuing dual-port
//  weight and feature-map reads every unstalled cycle, and emits the delayed
//  MAC, accumulator-clear and output-buffer write controls.
//  Ports:
//    clk    : rising-edge clock
//    reset  : synchronous, active-low reset
//    bus    : conv2_sched_if.slave (start/stall in; addresses, rd_valid,
//             mac_en, acc_clr, out_we, out_addr, out_init, busy, done out)
//  Revision: 1.0  initial release
// ============================================================================
module conv2_sched (
  input  logic         clk,
  input  logic         reset,
  conv2_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q;
  logic       drain_q;              // second DRAIN cycle marker
  logic [1:0] pair_q;
  logic [2:0] ox_q, oy_q;           // pos = oy*8 + ox
  logic [2:0] kx_q, ky_q;           // tap = ky*5 + kx

  // Stage 1: read data returns
  logic       mac_q, clr_q, last_q, init1_q;
  logic [5:0] pos1_q;
  // Stage 2: output-buffer write
  logic       we_q, oinit_q;
  logic [5:0] oaddr_q;

  logic       w_run, w_rd_valid;
  logic       w_kx_last, w_tap_last, w_pos_last, w_pass_last;
  logic [4:0] w_tap;
  logic [3:0] w_row, w_col;
  logic [7:0] w_k0;
  logic [9:0] w_fm0;

  assign w_run       = (state_q == S_RUN);
  assign w_rd_valid  = w_run & ~bus.stall;

  assign w_kx_last   = (kx_q == 3'd4);
  assign w_tap_last  = w_kx_last & (ky_q == 3'd4);
  assign w_pos_last  = w_tap_last & (ox_q == 3'd7) & (oy_q == 3'd7);
  assign w_pass_last = w_pos_last & (pair_q == 2'd2);

  assign w_tap = 5'(ky_q) * 5'd5 + 5'(kx_q);
  assign w_row = 4'(oy_q) + 4'(ky_q);
  assign w_col = 4'(ox_q) + 4'(kx_q);
  assign w_k0  = 8'(pair_q) * 8'd25 + 8'(w_tap);
  assign w_fm0 = 10'(pair_q) * 10'd144 + 10'(w_row) * 10'd12 + 10'(w_col);

  // Addresses are forced to zero outside RUN so idle outputs stay quiet;
  // port 1 sits three channels (3*144 words, 75 weights) above port 0.
  assign bus.k_addr0  = w_run ? w_k0 : 8'd0;
  assign bus.k_addr1  = w_run ? (w_k0 + 8'd75) : 8'd0;
  assign bus.fm_addr0 = w_run ? w_fm0 : 10'd0;
  assign bus.fm_addr1 = w_run ? (w_fm0 + 10'd432) : 10'd0;
  assign bus.rd_valid = w_rd_valid;
  assign bus.mac_en   = mac_q;
  assign bus.acc_clr  = clr_q;
  assign bus.out_we   = we_q;
  assign bus.out_addr = oaddr_q;
  assign bus.out_init = oinit_q;
  assign bus.busy     = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      drain_q <= 1'b0;
      pair_q  <= 2'd0;
      ox_q    <= 3'd0;
      oy_q    <= 3'd0;
      kx_q    <= 3'd0;
      ky_q    <= 3'd0;
      mac_q   <= 1'b0;
      clr_q   <= 1'b0;
      last_q  <= 1'b0;
      init1_q <= 1'b0;
      pos1_q  <= 6'd0;
      we_q    <= 1'b0;
      oinit_q <= 1'b0;
      oaddr_q <= 6'd0;
    end else begin
      // Return pipeline never stalls; it only follows what was issued.
      mac_q   <= w_rd_valid;
      clr_q   <= w_rd_valid & (w_tap == 5'd0);
      last_q  <= w_rd_valid & w_tap_last;
      init1_q <= (pair_q == 2'd0);
      pos1_q  <= {oy_q, ox_q};
      we_q    <= last_q;
      oinit_q <= last_q & init1_q;
      if (last_q) begin
        oaddr_q <= pos1_q;
      end

      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!bus.stall) begin
            kx_q <= w_kx_last ? 3'd0 : kx_q + 3'd1;
            if (w_kx_last) begin
              ky_q <= (ky_q == 3'd4) ? 3'd0 : ky_q + 3'd1;
            end
            if (w_tap_last) begin
              ox_q <= ox_q + 3'd1;
              if (ox_q == 3'd7) begin
                oy_q <= oy_q + 3'd1;
              end
            end
            if (w_pos_last) begin
              pair_q <= w_pass_last ? 2'd0 : pair_q + 2'd1;
            end
            if (w_pass_last) begin
              state_q <= S_DRAIN;
              drain_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2_sched.sv
`default_nettype none
// ============================================================================
//  tb_conv2_sched
//  Self-checking bench for conv2_sched. A behavioural model tracks the
//  number of taps issued and the issue index seen one and two cycles back;
//  every expected output is derived from that index with plain arithmetic.
//  Revision: 1.0  initial release
// ============================================================================
module tb_conv2_sched;

  logic clk = 1'b0;
  logic reset;
  conv2_sched_if bus ();

  conv2_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Model state
  bit m_run, m_done;
  int m_n, m_drain, h1, h2;
  int cur_scen;
  // Per-scenario statistics
  int n_mac, n_clr, n_we, n_init, n_done, done_cyc, first_done, first_we, n_stall;

  task automatic model_clear();
    m_run = 0; m_done = 0; m_n = 0; m_drain = 0; h1 = -1; h2 = -1;
  endtask

  task automatic step(input bit rn, input bit st, input bit sl, input int c, input bit zero_chk);
    logic [63:0] got, want, mask;
    bit e_rd, e_mac, e_clr, e_we, e_init, e_busy;
    int pair, pos, tap, k0, fm0;
    reset = rn; bus.start = st; bus.stall = sl;
    #1;
    e_rd   = m_run && !sl;
    e_busy = m_run || (m_drain > 0);
    e_mac  = (h1 >= 0);
    e_clr  = (h1 >= 0) && (h1 % 25 == 0);
    e_we   = (h2 >= 0) && (h2 % 25 == 24);
    e_init = (h2 >= 0) && (h2 / 1600 == 0);
    pair = m_n / 1600; pos = (m_n / 25) % 64; tap = m_n % 25;
    k0  = 25 * pair + tap;
    fm0 = pair * 144 + ((pos / 8) + (tap / 5)) * 12 + (pos % 8) + (tap % 5);
    got = {15'd0, bus.rd_valid, bus.mac_en, bus.acc_clr, bus.out_we, bus.busy, bus.done,
           bus.out_addr, bus.out_init, bus.k_addr0, bus.k_addr1, bus.fm_addr0, bus.fm_addr1};
    want = {15'd0, e_rd, e_mac, e_clr, e_we, e_busy, m_done,
            6'((h2 >= 0) ? (h2 / 25) % 64 : 0), e_init,
            8'(k0), 8'(k0 + 75), 10'(fm0), 10'(fm0 + 432)};
    mask = {15'd0, 6'h3f, {7{e_we}}, {36{m_run}}};
    if (zero_chk) begin
      check($sformatf("zero_c%0d", c), got, 64'd0);
    end else begin
      check($sformatf("s%0d_c%0d", cur_scen, c), got & mask, want & mask);
    end
    if (cur_scen == 0 && !zero_chk) begin
      if (c == 1) begin
        check("c1_k0", 64'(bus.k_addr0), 64'd0);
        check("c1_k1", 64'(bus.k_addr1), 64'd75);
        check("c1_fm0", 64'(bus.fm_addr0), 64'd0);
        check("c1_fm1", 64'(bus.fm_addr1), 64'd432);
      end
      if (c == 25) begin
        check("c25_k0", 64'(bus.k_addr0), 64'd24);
        check("c25_fm0", 64'(bus.fm_addr0), 64'd52);
      end
      if (c == 4800) begin
        check("c4800_k0", 64'(bus.k_addr0), 64'd74);
        check("c4800_k1", 64'(bus.k_addr1), 64'd149);
        check("c4800_fm0", 64'(bus.fm_addr0), 64'd431);
        check("c4800_fm1", 64'(bus.fm_addr1), 64'd863);
      end
    end
    if (cur_scen == 1 && c == 12) check("stall_hold_k0", 64'(bus.k_addr0), 64'd9);
    if (bus.mac_en)  n_mac++;
    if (bus.acc_clr) n_clr++;
    if (bus.out_we) begin
      n_we++;
      if (bus.out_init) n_init++;
      if (first_we < 0) first_we = c;
    end
    if (bus.done) begin
      n_done++;
      if (first_done < 0) first_done = c;
      done_cyc = c;
    end
    if (m_run && sl) n_stall++;
    // Model advance at the clock edge ending cycle c
    if (!rn) begin
      model_clear();
    end else begin
      h2 = h1;
      h1 = e_rd ? m_n : -1;
      if (m_run) begin
        if (!sl) begin
          m_n++;
          if (m_n == 4800) begin m_run = 0; m_drain = 2; end
        end
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_done = 1;
      end else if (m_done) begin
        m_done = 0;
      end else if (st) begin
        m_run = 1; m_n = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_scen(input int scen, input int passes);
    bit rn, st, sl, fin;
    cur_scen = scen;
    n_mac = 0; n_clr = 0; n_we = 0; n_init = 0; n_done = 0;
    done_cyc = -1; first_done = -1; first_we = -1; n_stall = 0; fin = 0;
    for (int c = 0; c < 12000; c++) begin
      rn = 1; st = (c == 0); sl = 0;
      case (scen)
        1: sl = (c >= 10 && c <= 14);
        2: sl = (c >= 4801);
        3: st = (c == 0 || c == 100 || c == 4803 || c == 4804);
        4: rn = (c != 2000);
        5: sl = ($urandom_range(3) == 0);
        default: ;
      endcase
      step(rn, st, sl, c, 0);
      if (scen == 4 && c == 2010) begin fin = 1; break; end
      if (scen != 4 && n_done == passes && c > done_cyc + 1) begin fin = 1; break; end
    end
    check($sformatf("s%0d_finished", scen), 64'(fin), 64'd1);
    if (scen == 4) begin
      check("s4_mac", 64'(n_mac), 64'd1999);
      check("s4_we", 64'(n_we), 64'd79);
      check("s4_done", 64'(n_done), 64'd0);
    end else begin
      check($sformatf("s%0d_mac", scen), 64'(n_mac), 64'(4800 * passes));
      check($sformatf("s%0d_clr", scen), 64'(n_clr), 64'(192 * passes));
      check($sformatf("s%0d_we", scen), 64'(n_we), 64'(192 * passes));
      check($sformatf("s%0d_init", scen), 64'(n_init), 64'(64 * passes));
      check($sformatf("s%0d_ndone", scen), 64'(n_done), 64'(passes));
      case (scen)
        0: begin
          check("s0_done_cyc", 64'(first_done), 64'd4803);
          check("s0_first_we", 64'(first_we), 64'd27);
        end
        1: check("s1_done_cyc", 64'(first_done), 64'd4808);
        2: check("s2_done_cyc", 64'(first_done), 64'd4803);
        3: begin
          check("s3_done_cyc", 64'(first_done), 64'd4803);
          check("s3_done2_cyc", 64'(done_cyc), 64'd9607);
        end
        default: check("s5_done_cyc", 64'(first_done), 64'(4803 + n_stall));
      endcase
    end
  endtask

  initial begin
    reset = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
    model_clear();
    cur_scen = -1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)  step(0, 0, 0, i, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, i, 1);
    run_scen(0, 1);
    run_scen(1, 1);
    run_scen(2, 1);
    run_scen(3, 2);
    run_scen(4, 0);
    run_scen(0, 1);
    run_scen(5, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv2_sched.md
# conv2_sched

Sequencer for the Convolution 2 layer. On `start` it walks 3 input-channel pairs × 64 output positions × 25 kernel taps, presenting dual-port weight-memory and feature-map read addresses every cycle. It emits pipelined MAC and accumulate controls, plus an output-buffer write strobe, so that each 8×8 output map accumulates all 6 input channels. It sits between the layer's top-level control and the conv2 weight ROM, pool1 feature RAM and MAC datapath.

## Interface
- `clk`  in  1  rising-edge clock; sole clock domain.
- `reset`  in  1  synchronous, active-low reset (sampled low at a rising edge of `clk`).
- `start`  in  1  begin one layer pass; accepted only in IDLE.
- `stall`  in  1  downstream backpressure; freezes address issue while high.
- `k_addr0`, `k_addr1`  out  8  weight-memory read addresses, ports 0/1.
- `fm_addr0`, `fm_addr1`  out  10  feature-map read addresses, ports 0/1.
- `rd_valid`  out  1  addresses on this cycle are a live read.
- `mac_en`  out  1  read data returned this cycle; multiply-accumulate it.
- `acc_clr`  out  1  with `mac_en`: tap 0 of a position; load the product instead of adding.
- `out_we`  out  1  write the accumulator to the output buffer.
- `out_addr`  out  6  output position, oy*8+ox.
- `out_init`  out  1  with `out_we`: pair 0, overwrite; else add to the stored partial sum.
- `busy`  out  1  high from the first RUN cycle through the last DRAIN cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM: IDLE → RUN (on `start`) → DRAIN (after the last issue) → DONE (1 cycle) → IDLE.
- Counters: `pair` 0..2 (outermost), `pos` 0..63 (raster, ox fastest), `tap` 0..24 (ky*5+kx, kx fastest).
- In RUN, when `stall` is low, `tap` advances each cycle.
  - At `tap`=24, `tap` wraps to 0 and `pos` increments.
  - At `pos`=63 with `tap`=24, `pos` wraps to 0 and `pair` increments.
  - At `pair`=2, `pos`=63, `tap`=24, the FSM moves to DRAIN.
- Address arithmetic (unsigned; all results fit the port width):
  - `k_addr0` = 25*pair + tap (0..74).
  - `k_addr1` = 75 + 25*pair + tap (75..149).
  - Port 0 reads channel `pair`; port 1 reads channel `pair`+3.
  - `fm_addrN` = ch*144 + (oy+ky)*12 + (ox+kx) over a 12×12 map; maximum value is 863.
- `rd_valid` = (state==RUN) & ~`stall`. The address outputs always reflect the current counters, including while stalled.
- Read latency is one cycle.
  - `mac_en` is `rd_valid` delayed one cycle.
  - `acc_clr` is (tap==0) delayed one cycle and qualified by `mac_en`.
- After the `mac_en` cycle that carries tap 24, the next cycle asserts `out_we` with `out_addr`=pos of that tap and `out_init`=(pair==0).
- `stall` only gates issue. The in-flight `mac_en` and `out_we` pipeline never stalls, and `stall` is ignored in DRAIN, DONE and IDLE.
- DRAIN lasts exactly 2 cycles, so the final `mac_en` and `out_we` are emitted.
- `start` is ignored in every state other than IDLE, including DONE.
- Reset low at any time, mid-pass included:
  - Next state is IDLE.
  - All counters and pipeline registers clear.
  - The in-flight pipeline is discarded; no trailing `mac_en` or `out_we` appears.

## Timing
- Reset values: all outputs 0. That is, all addresses 0 and `rd_valid`, `mac_en`, `acc_clr`, `out_we`, `out_addr`, `out_init`, `busy`, `done` all 0.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled high in IDLE.
- No-stall pass:
  - `rd_valid` is high for cycles 1..4800.
  - `mac_en` is high for cycles 2..4801.
  - First `out_we` is at cycle 27; last `out_we` is at cycle 4802.
  - `busy` is high for cycles 1..4802; `done` is high at cycle 4803.
  - The block is back in IDLE at cycle 4804, where a new `start` can be sampled.
- Stalls: each stalled RUN cycle lengthens the pass by exactly 1 cycle and produces a 1-cycle `mac_en` bubble one cycle later.
- Throughput: 1 tap per unstalled cycle. There are exactly 4800 `mac_en` pulses and 192 `out_we` pulses per pass.

## Test plan
- Reset then idle: hold `reset` low for 2 cycles, then high for 10 cycles with `start`=0 → every output stays 0.
- Single pass, no stall:
  - Cycle 1: `k_addr0`=0, `k_addr1`=75, `fm_addr0`=0, `fm_addr1`=432.
  - Cycle 25: `k_addr0`=24, `fm_addr0`=52.
  - Cycle 4800: `k_addr0`=74, `k_addr1`=149, `fm_addr0`=431, `fm_addr1`=863.
  - Pulse counts: 4800 `mac_en`, 64 `acc_clr` per pair, 192 `out_we`.
  - `out_init`=1 on only the first 64 writes; `done` at cycle 4803.
- Stall injection: hold `stall` high for cycles 10..14 → addresses hold the cycle-10 values, `mac_en` is low for cycles 11..15, and `done` moves to cycle 4808.
- Stall through the end: hold `stall` high from cycle 4801 onward → DRAIN is unaffected and `done` stays at cycle 4803.
- Ignored start: pulse `start` at cycles 100 and 4803 → there is no restart and `done` stays a single pulse; a `start` at cycle 4804 begins a new pass.
- Mid-run reset: drive `reset` low at cycle 2000 → outputs are 0 from cycle 2001 with no trailing `mac_en` or `out_we`; a following `start` yields a full 4800-tap pass.
